// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit.
// A WIDTH-bit operation runs through one DIGIT-bit ripple slice over NDIG
// cycles. A carry register links consecutive digits. Operands are taken and the
// result is returned with valid/ready handshakes. Subtraction is done as
// a + ~b + ~cin, and the unit also reports two's-complement overflow.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dig_sum;
  int               base;

  // Digit slice: add the selected digits of both operands and the carry.
  always_comb begin
    base    = int'(cnt_q) * DIGIT;
    a_dig   = a_q[base +: DIGIT];
    b_dig   = b_q[base +: DIGIT];
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  end

  // Next-state logic: control FSM, operand capture and digit write-back.
  // NOTE: every _d signal starts from its _q value, so no path through the
  // case statement can leave a signal unassigned. That rules out an inferred latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;      // subtract seeds the chain with ~cin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        s_d[base +: DIGIT] = dig_sum[DIGIT-1:0];
        carry_d            = dig_sum[DIGIT];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          cout_d  = dig_sum[DIGIT];
          // Carry into the MSB is a ^ b ^ sum at that bit.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ dig_sum[DIGIT-1] ^ dig_sum[DIGIT];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers, synchronously reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand registers: plain datapath.
  // NOTE: these are left out of reset on purpose. They are only read in RUN,
  // and every path into RUN loads them first.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder.
// The default instance (16/4) is driven from a vector table, a few random
// operations and hand-written corner sequences. Expected results pass through
// a scoreboard queue. Two more instances cover DIGIT=WIDTH and the DIGIT=1 case.
module tb_digit_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance: WIDTH=16, DIGIT=4.
  logic        iv, ir, ov, ordy, cin_i, sub_i, co_o, of_o;
  logic [15:0] a_i, b_i, s_o;

  // WIDTH=16, DIGIT=16.
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
  logic [15:0] a16, b16, s16;

  // WIDTH=12, DIGIT=1.
  logic        iv12, ir12, ov12, or12, cin12, sub12, co12, of12;
  logic [11:0] a12, b12, s12;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a_i), .b(b_i),
    .cin(cin_i), .sub(sub_i), .out_valid(ov), .out_ready(ordy), .s(s_o),
    .cout(co_o), .ovf(of_o)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .s(s16),
    .cout(co16), .ovf(of16)
  );

  digit_serial_adder #(.WIDTH(12), .DIGIT(1)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .a(a12), .b(b12),
    .cin(cin12), .sub(sub12), .out_valid(ov12), .out_ready(or12), .s(s12),
    .cout(co12), .ovf(of12)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: returns {ovf, cout, s[31:0]} for a w-bit operation.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin,
                                            input logic sub);
    logic [32:0] mask, sum;
    logic [31:0] aa, bb, ss;
    logic        c0, co, ov;
    mask = (33'd1 << w) - 33'd1;
    aa   = a & mask[31:0];
    bb   = (sub ? ~b : b) & mask[31:0];
    c0   = sub ? ~cin : cin;
    sum  = {1'b0, aa} + {1'b0, bb} + {32'd0, c0};
    ss   = sum[31:0] & mask[31:0];
    co   = sum[w];
    ov   = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
    return {ov, co, ss};
  endfunction

  // Present an operation, push its expected result and take the accept edge.
  // The inputs are then scrambled to show that the latched copy is used.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input exp_t e, input string name);
    int n = 0;
    a_i = a; b_i = b; cin_i = cin; sub_i = sub; iv = 1'b1;
    while (!ir && n < 20) begin step(); n++; end
    check({name, "_ready"}, {31'd0, ir}, 32'd1);
    sb.push_back(e);
    step();
    iv = 1'b0;
    a_i = ~a; b_i = ~b; cin_i = ~cin; sub_i = ~sub;
  endtask

  // Wait for out_valid and compare the result against the scoreboard head.
  task automatic collect(input string name);
    int   lat = 0;
    logic busy_ok = 1'b1;
    exp_t e;
    while (!ov && lat < 50) begin
      if (ir) busy_ok = 1'b0;
      step();
      lat++;
    end
    check({name, "_latency"}, lat, 32'd4);
    check({name, "_in_ready_low"}, {31'd0, busy_ok}, 32'd1);
    if (ov && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_s"}, {16'd0, s_o}, {16'd0, e.s});
      check({name, "_cout"}, {31'd0, co_o}, {31'd0, e.cout});
      check({name, "_ovf"}, {31'd0, of_o}, {31'd0, e.ovf});
    end else begin
      check({name, "_output_seen"}, {31'd0, ov}, 32'd1);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input exp_t e, input string name);
    ordy = 1'b1;
    issue(a, b, cin, sub, e, name);
    collect(name);
    step();
    check({name, "_idle_after"}, {30'd0, ir, ov}, 32'd2);
  endtask

  initial begin
    vec_t        vt[6];
    exp_t        e;
    logic [33:0] m;
    logic [15:0] hold_s;
    logic        stable, never;
    int          n, lat;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

    rst = 1'b1;
    iv = 0; ordy = 0; a_i = 0; b_i = 0; cin_i = 0; sub_i = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    iv12 = 0; or12 = 0; a12 = 0; b12 = 0; cin12 = 0; sub12 = 0;
    step(); step();

    // Reset state.
    check("rst_in_ready", {31'd0, ir}, 32'd0);
    check("rst_out_valid", {31'd0, ov}, 32'd0);
    check("rst_s", {16'd0, s_o}, 32'd0);
    check("rst_cout_ovf", {30'd0, co_o, of_o}, 32'd0);
    rst = 1'b0;
    step();
    check("rel_in_ready", {31'd0, ir}, 32'd1);

    // Vector table.
    foreach (vt[i]) begin
      e = '{vt[i].s, vt[i].cout, vt[i].ovf};
      do_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e, $sformatf("vec%0d", i));
    end

    // Random operations checked against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      m  = ref_model(16, {16'd0, ra}, {16'd0, rb}, rc, rs);
      e  = '{m[15:0], m[32], m[33]};
      do_op(ra, rb, rc, rs, e, $sformatf("rnd%0d", i));
    end

    // Backpressure: result held while a new operation waits at the input.
    ordy = 1'b0;
    issue(16'h0A0A, 16'h0505, 1'b0, 1'b0, '{16'h0F0F, 1'b0, 1'b0}, "bp");
    collect("bp");
    hold_s = s_o;
    a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b0; sub_i = 1'b0; iv = 1'b1;
    stable = 1'b1;
    repeat (6) begin
      step();
      if (s_o !== hold_s || co_o !== 1'b0 || of_o !== 1'b0 || ov !== 1'b1 || ir !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    ordy = 1'b1;
    step();
    check("bp_handshake_idle", {30'd0, ir, ov}, 32'd2);
    sb.push_back('{16'h3333, 1'b0, 1'b0});
    step();
    iv = 1'b0;
    check("bp_new_accepted", {31'd0, ir}, 32'd0);
    collect("bp_new");
    step();

    // Reset in the middle of RUN, after digits 0..2 have been written.
    issue(16'h1111, 16'h1111, 1'b0, 1'b0, '{16'h2222, 1'b0, 1'b0}, "rr");
    step(); step(); step();
    rst = 1'b1;
    step();
    check("rr_s", {16'd0, s_o}, 32'd0);
    check("rr_flags", {29'd0, ov, ir, co_o}, 32'd0);
    sb.delete();
    step();
    rst = 1'b0;
    never = 1'b1;
    repeat (8) begin
      step();
      if (ov) never = 1'b0;
    end
    check("rr_no_output", {31'd0, never}, 32'd1);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}, "rr_after");

    // DIGIT = WIDTH: single-cycle latency.
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; sub16 = 1'b0; or16 = 1'b1; iv16 = 1'b1;
    n = 0;
    while (!ir16 && n < 20) begin step(); n++; end
    step();
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin step(); lat++; end
    check("d16_latency", lat, 32'd1);
    check("d16_s", {16'd0, s16}, 32'h0000FFFF);
    check("d16_cout_ovf", {30'd0, co16, of16}, 32'd2);
    step();

    // WIDTH=12, DIGIT=1: random add/sub against the model.
    or12 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a12 = 12'($urandom); b12 = 12'($urandom);
      cin12 = 1'($urandom); sub12 = 1'($urandom);
      m = ref_model(12, {20'd0, a12}, {20'd0, b12}, cin12, sub12);
      iv12 = 1'b1;
      n = 0;
      while (!ir12 && n < 20) begin step(); n++; end
      step();
      iv12 = 1'b0;
      a12 = ~a12; b12 = ~b12;
      lat = 0;
      while (!ov12 && lat < 40) begin step(); lat++; end
      check($sformatf("d12_%0d_latency", i), lat, 32'd12);
      check($sformatf("d12_%0d_s", i), {20'd0, s12}, m[31:0]);
      check($sformatf("d12_%0d_flags", i), {30'd0, co12, of12}, {30'd0, m[32], m[33]});
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
